// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU opcodes, forwarding selects and control bundle
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

endpackage

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational ALU for the execute stage
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] w_shamt;
  logic       w_lt;

  assign w_shamt = b[4:0];
  assign w_lt    = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: result = a << w_shamt;
      ALU_SRL: result = a >> w_shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, ALU/JAL result, EX/MEM register
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteEnE,
  input  logic            MemtoRegE,
  input  logic            JALE,
  input  logic            MemReadEnE,
  input  logic            MemWriteEnE,
  input  logic [2:0]      ALUOpE,
  input  logic            ALUSrcE,
  input  logic [XLEN-1:0] ImmE,
  input  logic [REGW-1:0] RdE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ReadData1E,
  input  logic [XLEN-1:0] ReadData2E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            RegWriteEnM,
  output logic            MemtoRegM,
  output logic            MemReadEnM,
  output logic            MemWriteEnM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [REGW-1:0] RdM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic            ZeroM
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;
  logic [XLEN-1:0] w_ex_result;
  logic            w_ex_zero;
  ex_ctrl_t        w_ctrl_e;
  ex_ctrl_t        r_ctrl_m;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [REGW-1:0] r_rd;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_zero;

  // Select 11 is unused by the hazard unit and falls back to the register file value.
  always_comb begin
    w_src_a = ReadData1E;
    case (ForwardAE)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = r_alu_result;
      default: w_src_a = ReadData1E;
    endcase
  end

  always_comb begin
    w_fwd_b = ReadData2E;
    case (ForwardBE)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = r_alu_result;
      default: w_fwd_b = ReadData2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmE : w_fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (w_src_a),
    .b      (w_src_b),
    .op     (ALUOpE),
    .result (w_alu_result),
    .zero   (w_alu_zero)
  );

  assign w_ex_result = JALE ? PCPlus4E : w_alu_result;
  assign w_ex_zero   = JALE ? (PCPlus4E == '0) : w_alu_zero;

  assign w_ctrl_e = '{reg_write:  RegWriteEnE,
                      mem_to_reg: MemtoRegE,
                      mem_read:   MemReadEnE,
                      mem_write:  MemWriteEnE};

  // Flush kills the side-effecting controls but still lets data fields load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctrl_m     <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
      r_pc_plus4   <= '0;
      r_zero       <= 1'b0;
    end else if (FlushE) begin
      r_ctrl_m     <= '0;
      r_alu_result <= w_ex_result;
      r_write_data <= w_fwd_b;
      r_rd         <= '0;
      r_pc_plus4   <= PCPlus4E;
      r_zero       <= w_ex_zero;
    end else if (!StallE) begin
      r_ctrl_m     <= w_ctrl_e;
      r_alu_result <= w_ex_result;
      r_write_data <= w_fwd_b;
      r_rd         <= RdE;
      r_pc_plus4   <= PCPlus4E;
      r_zero       <= w_ex_zero;
    end
  end

  assign RegWriteEnM = r_ctrl_m.reg_write;
  assign MemtoRegM   = r_ctrl_m.mem_to_reg;
  assign MemReadEnM  = r_ctrl_m.mem_read;
  assign MemWriteEnM = r_ctrl_m.mem_write;
  assign ALUResultM  = r_alu_result;
  assign WriteDataM  = r_write_data;
  assign RdM         = r_rd;
  assign PCPlus4M    = r_pc_plus4;
  assign ZeroM       = r_zero;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed and random checks of execute_stage against a reference model
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE;
  logic [2:0]  ALUOpE;
  logic        ALUSrcE;
  logic [31:0] ImmE;
  logic [4:0]  RdE;
  logic [31:0] PCPlus4E, ReadData1E, ReadData2E, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallE, FlushE;
  logic        RegWriteEnM, MemtoRegM, MemReadEnM, MemWriteEnM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        ZeroM;

  int checks = 0;
  int errors = 0;

  logic        e_rw, e_m2r, e_mr, e_mw, e_zero;
  logic [31:0] e_alu, e_wd, e_pc;
  logic [4:0]  e_rd;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteEnE(RegWriteEnE), .MemtoRegE(MemtoRegE), .JALE(JALE),
    .MemReadEnE(MemReadEnE), .MemWriteEnE(MemWriteEnE),
    .ALUOpE(ALUOpE), .ALUSrcE(ALUSrcE), .ImmE(ImmE), .RdE(RdE),
    .PCPlus4E(PCPlus4E), .ReadData1E(ReadData1E), .ReadData2E(ReadData2E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE),
    .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .MemReadEnM(MemReadEnM),
    .MemWriteEnM(MemWriteEnM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M), .ZeroM(ZeroM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return e_alu;
    return regv;
  endfunction

  // Arithmetic reference: shifts as multiply/divide by powers of two, SLT on widened signed values.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned p2;
    p2 = 64'd1 << b[4:0];
    sa = a[31] ? longint'(a) - 64'h1_0000_0000 : longint'(a);
    sb = b[31] ? longint'(b) - 64'h1_0000_0000 : longint'(b);
    case (op)
      3'd0: return 32'(longint'(a) + longint'(b));
      3'd1: return 32'(longint'(a) - longint'(b));
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return 32'(longint'(a) * p2);
      default: return 32'(longint'(a) / p2);
    endcase
  endfunction

  task automatic check_all();
    chk("RegWriteEnM", 32'(RegWriteEnM), 32'(e_rw));
    chk("MemtoRegM",   32'(MemtoRegM),   32'(e_m2r));
    chk("MemReadEnM",  32'(MemReadEnM),  32'(e_mr));
    chk("MemWriteEnM", 32'(MemWriteEnM), 32'(e_mw));
    chk("ALUResultM",  ALUResultM,       e_alu);
    chk("WriteDataM",  WriteDataM,       e_wd);
    chk("RdM",         32'(RdM),         32'(e_rd));
    chk("PCPlus4M",    PCPlus4M,         e_pc);
    chk("ZeroM",       32'(ZeroM),       32'(e_zero));
  endtask

  task automatic step();
    logic [31:0] a, fb, b, res;
    a   = pick(ForwardAE, ReadData1E);
    fb  = pick(ForwardBE, ReadData2E);
    b   = ALUSrcE ? ImmE : fb;
    res = JALE ? PCPlus4E : ref_alu(ALUOpE, a, b);
    @(posedge clk);
    #1;
    if (!rst) begin
      {e_rw, e_m2r, e_mr, e_mw, e_zero} = '0;
      e_alu = '0; e_wd = '0; e_pc = '0; e_rd = '0;
    end else if (FlushE || !StallE) begin
      e_rw   = FlushE ? 1'b0 : RegWriteEnE;
      e_m2r  = FlushE ? 1'b0 : MemtoRegE;
      e_mr   = FlushE ? 1'b0 : MemReadEnE;
      e_mw   = FlushE ? 1'b0 : MemWriteEnE;
      e_rd   = FlushE ? 5'd0 : RdE;
      e_alu  = res;
      e_wd   = fb;
      e_pc   = PCPlus4E;
      e_zero = (res == 32'd0);
    end
    check_all();
  endtask

  task automatic nop_in();
    {RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE, StallE, FlushE} = '0;
    ALUOpE = 3'd0; ImmE = '0; RdE = '0; PCPlus4E = '0;
    ReadData1E = '0; ReadData2E = '0; ResultW = '0;
    ForwardAE = 2'd0; ForwardBE = 2'd0;
  endtask

  task automatic rand_in();
    {RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE} = 6'($urandom);
    JALE = ($urandom_range(0, 7) == 0);
    ALUOpE = 3'($urandom); ImmE = $urandom; RdE = 5'($urandom);
    PCPlus4E = $urandom; ReadData1E = $urandom; ReadData2E = $urandom; ResultW = $urandom;
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    if ($urandom_range(0, 5) == 0) ReadData2E = ReadData1E;
  endtask

  initial begin
    nop_in();
    rst = 1'b0;
    rand_in();
    step();
    rand_in();
    step();
    chk("reset_alu", ALUResultM, 32'd0);

    rst = 1'b1;
    nop_in(); RegWriteEnE = 1'b1; RdE = 5'd3; ReadData1E = 32'd5; ReadData2E = 32'd7;
    step();
    chk("add_5_7", ALUResultM, 32'd12);

    nop_in(); ALUOpE = 3'd1; ReadData1E = 32'd3; ReadData2E = 32'd3;
    step();
    chk("sub_zero", 32'(ZeroM), 32'd1);

    nop_in(); ALUOpE = 3'd5; ReadData1E = 32'hFFFF_FFFF; ReadData2E = 32'd1;
    step();
    chk("slt_neg", ALUResultM, 32'd1);

    nop_in(); ALUOpE = 3'd6; ALUSrcE = 1'b1; ImmE = 32'd31; ReadData1E = 32'd1;
    step();
    chk("sll_31", ALUResultM, 32'h8000_0000);

    nop_in(); ALUOpE = 3'd7; ReadData1E = 32'h8000_0000; ReadData2E = 32'd31;
    step();
    chk("srl_31", ALUResultM, 32'd1);

    nop_in(); ReadData1E = 32'd10; ReadData2E = 32'd20;
    step();
    nop_in(); ForwardAE = 2'b10; ReadData1E = 32'hDEAD_0000; ReadData2E = 32'd1;
    step();
    chk("fwd_mem", ALUResultM, 32'd31);

    nop_in(); MemWriteEnE = 1'b1; ALUSrcE = 1'b1; ImmE = 32'd8; ForwardBE = 2'b01;
    ResultW = 32'hAB; ReadData2E = 32'h55;
    step();
    chk("fwd_wb_store", WriteDataM, 32'hAB);

    nop_in(); JALE = 1'b1; PCPlus4E = 32'h104; ALUOpE = 3'd1; RdE = 5'd1; RegWriteEnE = 1'b1;
    ReadData1E = 32'd9; ReadData2E = 32'd2;
    step();
    chk("jal_result", ALUResultM, 32'h104);
    chk("jal_rd", 32'(RdM), 32'd1);

    for (int i = 0; i < 3; i++) begin
      rand_in();
      StallE = 1'b1;
      step();
      chk("stall_hold", ALUResultM, 32'h104);
    end

    nop_in(); StallE = 1'b1; FlushE = 1'b1; MemWriteEnE = 1'b1; RegWriteEnE = 1'b1; RdE = 5'd9;
    step();
    chk("flush_store", 32'(MemWriteEnM), 32'd0);
    chk("flush_rd", 32'(RdM), 32'd0);

    nop_in(); MemReadEnE = 1'b1; MemtoRegE = 1'b1; RegWriteEnE = 1'b1; RdE = 5'd4; ReadData1E = 32'h40;
    rst = 1'b0;
    step();
    chk("reset_mid_load", 32'(MemReadEnM), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      rand_in();
      rst    = ($urandom_range(0, 24) != 0);
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
